sap_control_sequencer: RTL and testbench

//  SAP-1 control sequencer: 6-state T-cycle ring (T1..T6) plus HALT state; fetches via PC/MAR/RAM/IR,

---
 rtl/sap_control_sequencer.sv | 147 ++++++++++++++
 tb/tb_sap_control_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sap_control_sequencer.sv
// SAP-1 control sequencer: T1..T6 ring plus absorbing HALT, strobe decode and retired-instruction counter.
// Optional SAP_SINGLE_STEP_EN adds a step input that gates state advance and all strobes.
module sap_control_sequencer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SAP_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [3:0]       op_code,
  output logic             pc_out,
  output logic             pc_inc,
  output logic             mar_load,
  output logic             ram_out,
  output logic             ir_load,
  output logic             ir_out,
  output logic             a_load,
  output logic             a_out,
  output logic             b_load,
  output logic             alu_out,
  output logic [2:0]       alu_op,
  output logic             flag_load,
  output logic             out_load,
  output logic             halted,
  output logic [2:0]       t_state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    T5   = 3'd5,
    T6   = 3'd6,
    HALT = 3'd7
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] op_q;
  logic [3:0] op_dec;
  logic       adv;
  logic       retire;
  logic       is_lda, is_alu, is_cmp, is_out, is_hlt;

`ifdef SAP_SINGLE_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  // T4 decodes the live IR nibble; T5/T6 only ever see the copy captured at T4.
  assign op_dec = (state == T4) ? op_code : op_q;
  assign is_lda = (op_dec == 4'h0);
  assign is_alu = (op_dec >= 4'h1) && (op_dec <= 4'h5);
  assign is_cmp = (op_dec == 4'h6);
  assign is_out = (op_dec == 4'hE);
  assign is_hlt = (op_dec == 4'hF);

  assign retire = adv && ((state == T6) || ((state == T4) && is_hlt));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= T1;
      op_q        <= '0;
      instr_count <= '0;
    end else if (adv) begin
      state <= state_nxt;
      if (state == T4) op_q <= op_code;
      if (retire && (instr_count != '1)) instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_out    = 1'b0;
    pc_inc    = 1'b0;
    mar_load  = 1'b0;
    ram_out   = 1'b0;
    ir_load   = 1'b0;
    ir_out    = 1'b0;
    a_load    = 1'b0;
    a_out     = 1'b0;
    b_load    = 1'b0;
    alu_out   = 1'b0;
    alu_op    = 3'b000;
    flag_load = 1'b0;
    out_load  = 1'b0;
    case (state)
      T1: state_nxt = T2;
      T2: state_nxt = T3;
      T3: state_nxt = T4;
      T4: state_nxt = is_hlt ? HALT : T5;
      T5: state_nxt = T6;
      T6: state_nxt = T1;
      default: state_nxt = HALT;
    endcase
    // A held (non-stepping) or resetting cycle must not load anything.
    if (!rst && adv) begin
      case (state)
        T1: begin
          pc_out   = 1'b1;
          mar_load = 1'b1;
        end
        T2: pc_inc = 1'b1;
        T3: begin
          ram_out = 1'b1;
          ir_load = 1'b1;
        end
        T4: begin
          if (is_lda || is_alu || is_cmp) begin
            ir_out   = 1'b1;
            mar_load = 1'b1;
          end else if (is_out) begin
            a_out    = 1'b1;
            out_load = 1'b1;
          end
        end
        T5: begin
          if (is_lda) begin
            ram_out = 1'b1;
            a_load  = 1'b1;
          end else if (is_alu || is_cmp) begin
            ram_out = 1'b1;
            b_load  = 1'b1;
          end
        end
        T6: begin
          if (is_alu) begin
            alu_out = 1'b1;
            a_load  = 1'b1;
            alu_op  = op_dec[2:0] - 3'd1;
          end else if (is_cmp) begin
            flag_load = 1'b1;
            alu_op    = 3'b001;
          end
        end
        default: ;
      endcase
    end
  end

  assign halted  = (state == HALT);
  assign t_state = state;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Randomized bench for sap_control_sequencer against an instruction-level reference model.
// Covers default CNT_W=8 and a CNT_W=2 instance; honours SAP_SINGLE_STEP_EN when defined.
module tb_sap_control_sequencer;

`ifdef SAP_SINGLE_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       step;
  logic [3:0] op_code;
  logic       pc_out, pc_inc, mar_load, ram_out, ir_load, ir_out;
  logic       a_load, a_out, b_load, alu_out, flag_load, out_load, halted;
  logic [2:0] alu_op, t_state;
  logic [7:0] instr_count;
  logic       halted2;
  logic [2:0] t_state2;
  logic [1:0] instr_count2;
  logic       u_pc_out, u_pc_inc, u_mar_load, u_ram_out, u_ir_load, u_ir_out;
  logic       u_a_load, u_a_out, u_b_load, u_alu_out, u_flag_load, u_out_load;
  logic [2:0] u_alu_op;

  sap_control_sequencer #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
`ifdef SAP_SINGLE_STEP_EN
    .step(step),
`endif
    .op_code(op_code),
    .pc_out(pc_out), .pc_inc(pc_inc), .mar_load(mar_load), .ram_out(ram_out),
    .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load), .a_out(a_out),
    .b_load(b_load), .alu_out(alu_out), .alu_op(alu_op), .flag_load(flag_load),
    .out_load(out_load), .halted(halted), .t_state(t_state), .instr_count(instr_count)
  );

  sap_control_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
`ifdef SAP_SINGLE_STEP_EN
    .step(step),
`endif
    .op_code(op_code),
    .pc_out(u_pc_out), .pc_inc(u_pc_inc), .mar_load(u_mar_load), .ram_out(u_ram_out),
    .ir_load(u_ir_load), .ir_out(u_ir_out), .a_load(u_a_load), .a_out(u_a_out),
    .b_load(u_b_load), .alu_out(u_alu_out), .alu_op(u_alu_op), .flag_load(u_flag_load),
    .out_load(u_out_load), .halted(halted2), .t_state(t_state2), .instr_count(instr_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: phase of the current instruction, captured opcode, retired count.
  int          m_ph  = 1;
  logic [3:0]  m_op  = 4'h0;
  int unsigned m_ret = 0;

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_edge();
    bit go;
    go = !STEP_EN || step;
    if (rst) begin
      m_ph  = 1;
      m_op  = 4'h0;
      m_ret = 0;
    end else if (m_ph != 7 && go) begin
      if (m_ph == 4) begin
        m_op = op_code;
        if (op_code == 4'hF) begin
          m_ph = 7;
          m_ret++;
        end else m_ph = 5;
      end else if (m_ph == 6) begin
        m_ph = 1;
        m_ret++;
      end else m_ph++;
    end
  endtask

  // {pc_out,pc_inc,mar_load,ram_out,ir_load,ir_out,a_load,a_out,b_load,alu_out,flag_load,out_load,alu_op}
  function automatic logic [14:0] expect_strobes(input int ph, input logic [3:0] op, input bit active);
    logic [11:0] s;
    logic [2:0]  aop;
    bit lda, alu, cmp, outi;
    s = '0;
    aop = 3'b000;
    lda = (op == 4'h0);
    alu = (op >= 4'h1 && op <= 4'h5);
    cmp = (op == 4'h6);
    outi = (op == 4'hE);
    if (active) begin
      case (ph)
        1: s = 12'b101000000000;
        2: s = 12'b010000000000;
        3: s = 12'b000110000000;
        4: if (lda || alu || cmp) s = 12'b001001000000;
           else if (outi) s = 12'b000000010001;
        5: if (lda) s = 12'b000100100000;
           else if (alu || cmp) s = 12'b000100001000;
        6: if (alu) begin
             s = 12'b000000100100;
             aop = op[2:0] - 3'd1;
           end else if (cmp) begin
             s = 12'b000000000010;
             aop = 3'b001;
           end
        default: s = '0;
      endcase
    end
    return {s, aop};
  endfunction

  task automatic check_outputs();
    logic [14:0] obs, exp, obs2;
    logic [3:0]  op;
    bit active;
    op = (m_ph == 4) ? op_code : m_op;
    active = !rst && (!STEP_EN || step) && (m_ph != 7);
    exp  = expect_strobes(m_ph, op, active);
    obs  = {pc_out, pc_inc, mar_load, ram_out, ir_load, ir_out, a_load, a_out,
            b_load, alu_out, flag_load, out_load, alu_op};
    obs2 = {u_pc_out, u_pc_inc, u_mar_load, u_ram_out, u_ir_load, u_ir_out, u_a_load, u_a_out,
            u_b_load, u_alu_out, u_flag_load, u_out_load, u_alu_op};
    check("strobes", {17'd0, obs}, {17'd0, exp});
    check("strobes_w2", {17'd0, obs2}, {17'd0, exp});
    check("t_state", {29'd0, t_state}, m_ph);
    check("halted", {31'd0, halted}, {31'd0, (m_ph == 7)});
    check("instr_count", {24'd0, instr_count}, sat(m_ret, 255));
    check("instr_count_w2", {30'd0, instr_count2}, sat(m_ret, 3));
    check("one_bus_driver", {31'd0, ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) <= 1)}, 32'd1);
  endtask

  task automatic tick(input logic n_rst, input logic [3:0] n_op, input logic n_step);
    @(posedge clk);
    model_edge();
    #1;
    rst = n_rst;
    op_code = n_op;
    step = n_step;
    #1;
    check_outputs();
  endtask

  function automatic logic [3:0] pick_op(input bit allow_hlt);
    if (allow_hlt && $urandom_range(0, 99) < 3) return 4'hF;
    return 4'($urandom_range(0, 14));
  endfunction

  int unsigned halt_cycles;
  bit          reached;

  initial begin
    rst = 1'b1;
    op_code = 4'h0;
    step = 1'b1;
    repeat (3) tick(1'b1, 4'h0, 1'b1);
    tick(1'b0, 4'h0, 1'b1);

    // Mixed random traffic: occasional reset, halts, and step gaps.
    halt_cycles = 0;
    for (int i = 0; i < 800; i++) begin
      logic r;
      r = ($urandom_range(0, 99) == 0) || (halt_cycles > 20);
      halt_cycles = (m_ph == 7) ? halt_cycles + 1 : 0;
      tick(r, pick_op(1'b1), ($urandom_range(0, 99) < 80));
    end
    tick(1'b1, 4'h0, 1'b1);
    tick(1'b0, 4'h0, 1'b1);

    // Directed halt: hold HLT on the IR until HALT is entered, sit there, then reset.
    reached = 1'b0;
    for (int i = 0; i < 30 && !reached; i++) begin
      tick(1'b0, 4'hF, 1'b1);
      reached = (m_ph == 7);
    end
    check("halt_reached", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 20; i++) tick(1'b0, pick_op(1'b1), $urandom_range(0, 1) == 1);
    tick(1'b1, 4'h0, 1'b1);
    tick(1'b0, 4'h0, 1'b1);

    // Long run without reset or HLT drives both counters into saturation.
    for (int i = 0; i < 3000; i++) tick(1'b0, pick_op(1'b0), ($urandom_range(0, 99) < 90));
    check("sat8", {24'd0, instr_count}, 32'hFF);
    check("sat2", {30'd0, instr_count2}, 32'h3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
